// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_MEM_WAIT  = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_STOP      = 3'd5
  } state_t;

  // Only register-register and register-immediate ALU words go to the decoder.
  localparam logic [6:0] R_TYPE_OP = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP = 7'b0010011;

  function automatic logic is_legal_op(input logic [31:0] word);
    return (word[6:0] == R_TYPE_OP) || (word[6:0] == I_TYPE_OP);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port plus decoder issue/complete handshake.
interface instr_sequencer_if #(
  parameter int IMEM_AW = 8
);
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        instruction;
  logic               instruction_RDY_BSY;
  logic               dec_done;

  // The sequencer drives fetch and issue, and listens to memory data and completion.
  modport master (
    output imem_en, imem_addr, instruction, instruction_RDY_BSY,
    input  imem_rdata, dec_done
  );

  // Memory and decoder side of the same bundle.
  modport slave (
    input  imem_en, imem_addr, instruction, instruction_RDY_BSY,
    output imem_rdata, dec_done
  );
endinterface

// File: rtl/sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment; increment stops once the counter is full.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: reads words from instruction memory, hands legal
// R/I-type words to the decoder with a one-cycle pulse, waits for writeback,
// and tracks cycle, retired and illegal-word counts.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int IMEM_AW      = 8,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IMEM_AW-1:0]  start_pc,
  input  logic                halt_req,
  instr_sequencer_if.master   bus,
  output logic                busy,
  output logic                halted,
  output logic                timeout_err,
  output logic [31:0]         cycle_counter,
  output logic [31:0]         instr_counter,
  output logic [15:0]         illegal_counter
);
  // Timer only has to reach DONE_TIMEOUT-1.
  localparam int TW = $clog2(DONE_TIMEOUT);

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [TW-1:0]      timer_inc;
  logic               halt_pend_q, halt_pend_d;
  logic               tout_q, tout_d;
  logic               busy_w;
  logic               cnt_clr, instr_inc, ill_inc;

  assign busy_w    = (state_q != S_IDLE) && (state_q != S_STOP);
  assign timer_inc = timer_q + TW'(1);

  // Next-state and datapath decisions.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    timer_d     = timer_q;
    halt_pend_d = halt_pend_q;
    tout_d      = tout_q;
    cnt_clr     = 1'b0;
    instr_inc   = 1'b0;
    ill_inc     = 1'b0;

    if (busy_w && halt_req) begin
      halt_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_STOP: begin
        if (start) begin
          pc_d        = start_pc;
          cnt_clr     = 1'b1;
          halt_pend_d = 1'b0;
          tout_d      = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        instr_d = bus.imem_rdata;
        if (is_legal_op(bus.imem_rdata)) begin
          state_d = S_ISSUE;
        end else begin
          ill_inc = 1'b1;
          pc_d    = pc_q + IMEM_AW'(1);
          state_d = halt_pend_q ? S_STOP : S_FETCH;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // timer_inc counts WAIT_DONE cycles, so the stop lands DONE_TIMEOUT
        // cycles after the issue pulse; a completion in that last cycle wins.
        timer_d = timer_inc;
        if (bus.dec_done) begin
          instr_inc = 1'b1;
          pc_d      = pc_q + IMEM_AW'(1);
          state_d   = halt_pend_q ? S_STOP : S_FETCH;
        end else if (timer_inc == TW'(DONE_TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      timer_q     <= '0;
      halt_pend_q <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      timer_q     <= timer_d;
      halt_pend_q <= halt_pend_d;
      tout_q      <= tout_d;
    end
  end

  sat_counter #(.WIDTH(32)) u_cycle_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(busy_w), .count_o(cycle_counter)
  );
  sat_counter #(.WIDTH(32)) u_instr_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(instr_inc), .count_o(instr_counter)
  );
  sat_counter #(.WIDTH(16)) u_illegal_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(ill_inc), .count_o(illegal_counter)
  );

  assign bus.imem_en             = (state_q == S_FETCH);
  assign bus.imem_addr           = pc_q;
  assign bus.instruction         = instr_q;
  assign bus.instruction_RDY_BSY = (state_q == S_ISSUE);
  assign busy                    = busy_w;
  assign halted                  = (state_q == S_STOP);
  assign timeout_err             = tout_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a cycle-timeline model predicts each
// issue pulse and the final stop state; a monitor compares what the DUT shows.
module tb_instr_sequencer;
  localparam int AW = 3;
  localparam int D  = 6;
  localparam int NW = 1 << AW;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] ADDI = 32'h00508093;
  localparam logic [31:0] LOAD = 32'h00000003;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          halt_req = 1'b0;
  logic          busy, halted, timeout_err;
  logic [31:0]   cycle_counter, instr_counter;
  logic [15:0]   illegal_counter;

  instr_sequencer_if #(.IMEM_AW(AW)) bus();

  instr_sequencer #(.IMEM_AW(AW), .DONE_TIMEOUT(D)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .halt_req(halt_req),
    .bus(bus), .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .cycle_counter(cycle_counter), .instr_counter(instr_counter),
    .illegal_counter(illegal_counter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction memory.
  logic [31:0] mem [NW];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  typedef struct { logic [31:0] word; int cyc; } issue_t;
  typedef struct { int cyc; int ins; int ill; int cycles; bit tout; int pc; } fin_t;

  issue_t exp_q[$];
  fin_t   fin_q[$];
  int     dec_lat_q[$];
  int     lats[64];
  int     done_at = -1;
  int     checks = 0;
  int     failures = 0;
  bit     halted_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_w(input logic [31:0] w);
    return (w[6:0] == 7'h33) || (w[6:0] == 7'h13);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0]  bad [9] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h37, 7'h00, 7'h7f, 7'h32, 7'h17};
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 9);
    if (r < 4) w[6:0] = 7'h33;
    else if (r < 8) w[6:0] = 7'h13;
    else w[6:0] = bad[$urandom_range(0, 8)];
    return w;
  endfunction

  // Decoder model: completion pulse a chosen number of cycles after each issue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.instruction_RDY_BSY) begin
        if (dec_lat_q.size() > 0) done_at = cyc + dec_lat_q.pop_front();
        else done_at = -1;
      end
    end
  end
  initial begin
    bus.dec_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.dec_done = (cyc == done_at);
    end
  end

  // Monitor: pops expectations whenever the DUT issues or stops.
  initial begin
    issue_t e;
    fin_t   f;
    forever begin
      @(negedge clk);
      if (bus.instruction_RDY_BSY) begin
        $display("issue cycle=%0d instr=%08h", cyc, bus.instruction);
        if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("issue_word", bus.instruction, e.word);
          chk("issue_cycle", cyc, e.cyc);
        end
      end
      if (halted && !halted_prev) begin
        $display("stop  cycle=%0d instr=%0d illegal=%0d cycles=%0d tout=%0d pc=%0d",
                 cyc, instr_counter, illegal_counter, cycle_counter, timeout_err, bus.imem_addr);
        if (fin_q.size() == 0) chk("unexpected_stop", 1, 0);
        else begin
          f = fin_q.pop_front();
          chk("stop_cycle", cyc, f.cyc);
          chk("instr_counter", instr_counter, f.ins);
          chk("illegal_counter", illegal_counter, f.ill);
          chk("cycle_counter", cycle_counter, f.cycles);
          chk("timeout_err", timeout_err, f.tout);
          chk("final_pc", bus.imem_addr, f.pc);
        end
      end
      halted_prev = halted;
    end
  end

  // Timeline model: start seen in cycle s, first fetch in s+1. Each word costs
  // fetch + read; a legal one is issued two cycles after its fetch and either
  // completes after its latency or stops DONE_TIMEOUT cycles after issue.
  // A halt request counts if it arrived in a busy cycle before the decision.
  task automatic model_run(input int s, input int spc, input int halt_cyc);
    int c = s + 1;
    int pc = spc;
    int k = 0, ill = 0, ins = 0, lat = 0, dec = 0;
    bit tout = 1'b0;
    logic [31:0] w;
    issue_t e;
    fin_t f;
    forever begin
      w = mem[pc];
      if (legal_w(w)) begin
        e.word = w;
        e.cyc  = c + 2;
        exp_q.push_back(e);
        lat = (k < 64) ? lats[k] : 1;
        k++;
        dec_lat_q.push_back(lat);
        if (lat <= D - 1) begin
          dec = c + 2 + lat;
          ins++;
          pc = (pc + 1) % NW;
        end else begin
          dec  = c + 2 + D - 1;
          tout = 1'b1;
        end
      end else begin
        dec = c + 1;
        ill++;
        pc = (pc + 1) % NW;
      end
      if (tout || (halt_cyc > s && halt_cyc < dec) || c > s + 500) break;
      c = dec + 1;
    end
    f.cyc = dec + 1; f.ins = ins; f.ill = ill; f.cycles = dec - s; f.tout = tout; f.pc = pc;
    fin_q.push_back(f);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_cycle_counter"}, cycle_counter, 0);
    chk({tag, "_instr_counter"}, instr_counter, 0);
    chk({tag, "_illegal_counter"}, illegal_counter, 0);
    chk({tag, "_imem_en"}, bus.imem_en, 0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 0);
    chk({tag, "_instruction"}, bus.instruction, 0);
    chk({tag, "_rdy"}, bus.instruction_RDY_BSY, 0);
  endtask

  task automatic do_run(input int spc, input int halt_off, input bit hws, input string tag);
    int s;
    int n = 0;
    tick();
    s = cyc;
    start = 1'b1;
    start_pc = AW'(spc);
    halt_req = hws;
    model_run(s, spc, (halt_off > 0) ? s + halt_off : -1);
    $display("run %s start cycle=%0d pc=%0d halt_off=%0d", tag, s, spc, halt_off);
    do begin
      tick();
      n++;
      start = 1'b0;
      halt_req = (halt_off > 0) && (cyc == s + halt_off);
    end while (!halted && n < 700);
    halt_req = 1'b0;
    chk("stop_reached", halted, 1);
    if (!halted) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    repeat (D + 4) tick();
    chk("issues_drained", exp_q.size(), 0);
    chk("stops_drained", fin_q.size(), 0);
    exp_q.delete();
    fin_q.delete();
    dec_lat_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    issue_t e;
    for (int i = 0; i < NW; i++) mem[i] = LOAD;
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Three legal words, halt while the third is in flight.
    for (int i = 0; i < NW; i++) mem[i] = LOAD;
    mem[0] = ADD; mem[1] = ADDI; mem[2] = ADD;
    for (int i = 0; i < 64; i++) lats[i] = 2;
    do_run(0, 12, 1'b0, "three_legal");

    // Illegal word skipped, next word issued five cycles after start.
    for (int i = 0; i < NW; i++) mem[i] = ADD;
    mem[0] = LOAD;
    lats[0] = 1;
    do_run(0, 5, 1'b0, "skip_illegal");

    // Decoder never answers inside the window: timeout stop.
    for (int i = 0; i < NW; i++) mem[i] = ADD;
    lats[0] = D;
    do_run(0, -1, 1'b0, "timeout");

    // Completion on the final timeout cycle wins.
    lats[0] = D - 1;
    do_run(0, 2, 1'b1, "late_done");

    // PC wrap from all-ones to zero.
    for (int i = 0; i < NW; i++) mem[i] = 32'h00000033 | (32'(i) << 12);
    lats[0] = 1; lats[1] = 1;
    do_run(NW - 1, 5, 1'b0, "wrap");

    // Randomised programs, latencies and halt timing.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NW; i++) mem[i] = rand_word();
      for (int i = 0; i < 64; i++)
        lats[i] = ($urandom_range(0, 7) == 0) ? D + $urandom_range(0, 2) : $urandom_range(1, D - 1);
      do_run($urandom_range(0, NW - 1), $urandom_range(1, 40), 1'($urandom_range(0, 1)), "random");
    end

    // Reset while waiting for completion; the late completion must be ignored.
    for (int i = 0; i < NW; i++) mem[i] = ADD;
    tick();
    s = cyc;
    start = 1'b1;
    start_pc = '0;
    e.word = ADD;
    e.cyc = s + 3;
    exp_q.push_back(e);
    dec_lat_q.push_back(3);
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("busy_before_reset", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_run_reset");
    repeat (D + 3) tick();
    chk("late_done_ignored_instr", instr_counter, 0);
    chk("late_done_ignored_busy", busy, 0);
    chk("reset_issue_seen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
